compensation_weight_extractor: RTL and testbench
================================================

Name: compensation_weight_extractor

Overview:
- Sits directly upstream of the compensation memory. Scans an 8-bit signed weight tile column-by-column: SIZE columns, SIZE rows each.
- For each weight whose magnitude exceeds the outlier threshold, emits the 3-bit row index as a compensation entry.
- Also produces the column-advance and load-complete controls the memory consumes: change_col and load_mem_done.
- Each memory column group holds exactly 3 entries. This block guarantees the memory's write index ends every column on a 3-slot boundary.

Parameters:
- SIZE, 8, systolic array dimension (rows per column and number of columns); must be 8 so a row index fits in 3 bits.
- WEIGHT_WIDTH, 8, signed weight width.
- OUTLIER_TH, 63, weight is an outlier when |w| > OUTLIER_TH; |-128| = 128.
- MAX_PER_COL, 3, compensation slots per column.
- PAD_CODE, 3'b000, code written into slots of an all-clean column.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a tile scan (ignored unless IDLE or DONE)
- weight_in  in  WEIGHT_WIDTH  signed weight, row-major within column, column 0 first
- weight_valid  in  1  weight_in valid
- weight_ready  out  1  block accepts weight_in this cycle
- Compensation_Weight  out  3  row index of outlier (or PAD_CODE)
- Compensation_out_valid  out  1  Compensation_Weight valid, one-cycle pulse per entry
- change_col  out  1  one-cycle pulse: advance memory to next column group
- load_mem_done  out  1  level; all SIZE columns processed
- overflow  out  1  sticky; some column had more than MAX_PER_COL outliers
- busy  out  1  high in SCAN or FLUSH

Behaviour:
- Synchronous reset, active-high. On reset:
  - state = IDLE; row, col and cnt counters = 0.
  - All outputs = 0, including overflow and load_mem_done.
- Reset mid-scan aborts the scan with no further output.
- IDLE:
  - weight_ready = 0.
  - start -> SCAN; clears load_mem_done, overflow and all counters.
- SCAN:
  - weight_ready = 1. A transfer occurs on weight_valid & weight_ready.
  - Per transfer: outlier test on weight_in. If outlier and cnt < MAX_PER_COL:
    - next cycle (registered, latency 1): Compensation_out_valid = 1, Compensation_Weight = row[2:0];
    - cnt++.
  - If outlier and cnt == MAX_PER_COL: entry dropped, overflow set.
  - row++ per transfer. On the transfer with row == SIZE-1 -> FLUSH, row = 0.
  - weight_valid low stalls the scan; no state change.
- FLUSH: weight_ready = 0. Action depends on cnt:
  - cnt == 0: emit 3 PAD_CODE entries on 3 consecutive cycles; no change_col.
  - cnt in 1..2: one cycle after the last entry, pulse change_col alone, with Compensation_out_valid = 0.
  - cnt == 3: no pulse; the memory index is already aligned.
- change_col never coincides with Compensation_out_valid.
- End of FLUSH: cnt = 0, col++.
  - col == SIZE-1 -> DONE.
  - otherwise -> SCAN.
- DONE:
  - load_mem_done = 1, held until the next start or reset.
  - weight_ready = 0.
  - start -> SCAN with load_mem_done cleared the same cycle.
- start during SCAN or FLUSH: ignored.
- Outputs never go X; Compensation_Weight holds its last value when not valid.
- Outlier test uses a WEIGHT_WIDTH+1-bit absolute value so -128 does not wrap.

Decomposition:
- Shared package holds:
  - SIZE, MAX_PER_COL, PAD_CODE;
  - state enum IDLE/SCAN/FLUSH/DONE;
  - compensation code width (3).
- One natural sub-module: outlier_detector. Combinational abs/compare of weight_in against OUTLIER_TH; output is_outlier.

Test Plan:
- Clean tile: 64 weights of value 10, start -> 8x3 PAD_CODE entries, zero change_col pulses, load_mem_done rises after the last pad, overflow = 0.
- Column 0 outliers at rows 1 and 5 (values 100, -100), rest clean -> entries 3'd1 then 3'd5, each 1 cycle after acceptance, then one isolated change_col pulse.
- Column 2 outliers at rows 0, 2, 4, 6 (value -128) -> entries 0, 2, 4; row 6 dropped; overflow = 1 and sticky; no change_col for that column.
- Boundary: weights 63 and -63 -> no entry; 64 and -64 -> entry.
- Random weight_valid gaps (50%) on the same tile as scenario 2 -> identical entry sequence and pulse order; no accepted weight lost.
- Reset asserted mid-SCAN at column 4 -> next cycle all outputs 0, state IDLE. A fresh start then reproduces the full scenario-1 sequence.

Source files
------------

// File: rtl/compensation_weight_extractor_pkg.sv
// Shared constants and types for the compensation weight extractor.
// The array is fixed at 8x8 so that a row index fits the 3-bit code.
package compensation_weight_extractor_pkg;

  localparam int SIZE        = 8;
  localparam int MAX_PER_COL = 3;

  localparam int CODE_W = 3;  // compensation code (row index) width
  localparam int ROW_W  = 3;  // row counter width
  localparam int COL_W  = 3;  // column counter width
  localparam int CNT_W  = 2;  // per-column entry counter width (0..MAX_PER_COL)

  localparam logic [CODE_W-1:0] PAD_CODE = 3'b000;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SIZE - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PER_COL);
  localparam logic [CNT_W-1:0] LAST_PAD = CNT_W'(MAX_PER_COL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/compensation_weight_extractor_outlier_detector.sv
// Combinational outlier test: |weight| > threshold.
// The magnitude is one bit wider than the weight so the most negative
// value (-128 for 8 bits) yields +128 instead of wrapping.
module outlier_detector #(
  parameter int WEIGHT_WIDTH = 8,
  parameter int OUTLIER_TH   = 63
) (
  input  logic signed [WEIGHT_WIDTH-1:0] i_weight,
  output logic                           o_is_outlier
);

  localparam logic [WEIGHT_WIDTH:0] TH = (WEIGHT_WIDTH + 1)'(OUTLIER_TH);

  logic [WEIGHT_WIDTH:0] w_ext;
  logic [WEIGHT_WIDTH:0] w_abs;

  assign w_ext        = {i_weight[WEIGHT_WIDTH-1], i_weight};
  assign w_abs        = w_ext[WEIGHT_WIDTH] ? -w_ext : w_ext;
  assign o_is_outlier = (w_abs > TH);

endmodule

// File: rtl/compensation_weight_extractor.sv
// Scans a weight tile column by column and emits the row index of every
// outlier weight (up to MAX_PER_COL per column) for the compensation memory.
// At the end of each column the memory write index is realigned to a
// MAX_PER_COL-slot boundary: clean columns get PAD_CODE entries, partially
// filled columns get a change_col pulse, full columns need nothing.
module compensation_weight_extractor
  import compensation_weight_extractor_pkg::*;
#(
  parameter int WEIGHT_WIDTH = 8,
  parameter int OUTLIER_TH   = 63
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic signed [WEIGHT_WIDTH-1:0] weight_in,
  input  logic                           weight_valid,
  output logic                           weight_ready,
  output logic [CODE_W-1:0]              Compensation_Weight,
  output logic                           Compensation_out_valid,
  output logic                           change_col,
  output logic                           load_mem_done,
  output logic                           overflow,
  output logic                           busy
);

  state_e              r_state;
  state_e              w_next_state;

  logic [ROW_W-1:0]    r_row;
  logic [COL_W-1:0]    r_col;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_pad_phase;

  logic                r_comp_valid;
  logic [CODE_W-1:0]   r_comp_weight;
  logic                r_change_col;
  logic                r_load_mem_done;
  logic                r_overflow;

  logic                w_ready;
  logic                w_busy;
  logic                w_xfer;
  logic                w_is_outlier;
  logic                w_start_ok;
  logic                w_flush_last;

  outlier_detector #(
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .OUTLIER_TH   (OUTLIER_TH)
  ) u_outlier_detector (
    .i_weight     (weight_in),
    .o_is_outlier (w_is_outlier)
  );

  assign w_xfer     = weight_valid && w_ready;
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

  // A clean column spends one cycle per pad slot in FLUSH; any other
  // column leaves FLUSH after a single cycle.
  assign w_flush_last = (r_cnt != '0) || (r_pad_phase == LAST_PAD);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves the
    // signal unassigned (which would infer a latch).
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = SCAN;
      SCAN:    if (w_xfer && (r_row == LAST_ROW)) w_next_state = FLUSH;
      FLUSH:   if (w_flush_last) w_next_state = (r_col == LAST_COL) ? DONE : SCAN;
      DONE:    if (start) w_next_state = SCAN;
      default: w_next_state = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      SCAN: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
      end
      FLUSH:   w_busy = 1'b1;
      default: ;
    endcase
  end

  // Counters and registered entry / control outputs.
  always_ff @(posedge clk) begin
    // NOTE: every register here is reset so the outputs are defined from the
    // first cycle after reset and a reset mid-scan leaves nothing pending.
    if (rst) begin
      r_row           <= '0;
      r_col           <= '0;
      r_cnt           <= '0;
      r_pad_phase     <= '0;
      r_comp_valid    <= 1'b0;
      r_comp_weight   <= '0;
      r_change_col    <= 1'b0;
      r_load_mem_done <= 1'b0;
      r_overflow      <= 1'b0;
    end else begin
      r_comp_valid <= 1'b0;
      r_change_col <= 1'b0;

      if (w_start_ok) begin
        r_row           <= '0;
        r_col           <= '0;
        r_cnt           <= '0;
        r_pad_phase     <= '0;
        r_load_mem_done <= 1'b0;
        r_overflow      <= 1'b0;
      end else begin
        case (r_state)
          SCAN: begin
            if (w_xfer) begin
              if (w_is_outlier) begin
                if (r_cnt < MAX_CNT) begin
                  r_comp_valid  <= 1'b1;
                  r_comp_weight <= r_row;
                  r_cnt         <= r_cnt + 1'b1;
                end else begin
                  r_overflow <= 1'b1;
                end
              end
              r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
            end
          end

          FLUSH: begin
            if (r_cnt == '0) begin
              r_comp_valid  <= 1'b1;
              r_comp_weight <= PAD_CODE;
              r_pad_phase   <= r_pad_phase + 1'b1;
            end else if (r_cnt < MAX_CNT) begin
              r_change_col <= 1'b1;
            end
            if (w_flush_last) begin
              r_pad_phase <= '0;
              r_cnt       <= '0;
              r_col       <= r_col + 1'b1;
            end
          end

          DONE:    r_load_mem_done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign weight_ready           = w_ready;
  assign busy                   = w_busy;
  assign Compensation_Weight    = r_comp_weight;
  assign Compensation_out_valid = r_comp_valid;
  assign change_col             = r_change_col;
  assign load_mem_done          = r_load_mem_done;
  assign overflow               = r_overflow;

endmodule

// File: tb/tb_compensation_weight_extractor.sv
// Scoreboard bench for compensation_weight_extractor: the driver computes the
// expected entry / change_col stream from the tile and queues it; a monitor
// pops and compares as the DUT produces output.
module tb_compensation_weight_extractor;

  logic              clk;
  logic              rst;
  logic              start;
  logic signed [7:0] weight_in;
  logic              weight_valid;
  logic              weight_ready;
  logic [2:0]        Compensation_Weight;
  logic              Compensation_out_valid;
  logic              change_col;
  logic              load_mem_done;
  logic              overflow;
  logic              busy;

  compensation_weight_extractor dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .weight_in              (weight_in),
    .weight_valid           (weight_valid),
    .weight_ready           (weight_ready),
    .Compensation_Weight    (Compensation_Weight),
    .Compensation_out_valid (Compensation_out_valid),
    .change_col             (change_col),
    .load_mem_done          (load_mem_done),
    .overflow               (overflow),
    .busy                   (busy)
  );

  typedef struct {
    bit         is_cc;   // 1: change_col pulse, 0: compensation entry
    logic [2:0] code;
    int         cyc;     // required output cycle, -1 when not timed
  } item_t;

  item_t             sb[$];
  logic signed [7:0] tile [64];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                cyc      = 0;
  bit                exp_ovf;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: every entry or change_col pulse is matched against the queue.
  always @(negedge clk) begin
    if (!rst && (Compensation_out_valid || change_col)) begin
      check("cc_excl", int'(Compensation_out_valid && change_col), 0);
      check("done_early", int'(load_mem_done), 0);
      if (sb.size() == 0) begin
        check("spurious_output", 1, 0);
      end else begin
        item_t it;
        it = sb.pop_front();
        check("kind_is_cc", int'(change_col), int'(it.is_cc));
        if (!it.is_cc) begin
          check("code", int'(Compensation_Weight), int'(it.code));
          if (it.cyc >= 0) check("latency", cyc, it.cyc);
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, int'(Compensation_out_valid), 0);
    check({tag, "_cc"},    int'(change_col), 0);
    check({tag, "_code"},  int'(Compensation_Weight), 0);
    check({tag, "_done"},  int'(load_mem_done), 0);
    check({tag, "_ovf"},   int'(overflow), 0);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_ready"}, int'(weight_ready), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // One weight transfer; returns the cycle number of the accepting edge.
  task automatic send(input logic signed [7:0] w, input bit with_start, output int acc);
    int guard;
    guard        = 0;
    acc          = -1;
    weight_in    = w;
    weight_valid = 1'b1;
    start        = with_start;
    forever begin
      @(negedge clk);
      if (weight_ready) break;
      guard++;
      if (guard > 50) begin
        check("ready_timeout", 0, 1);
        weight_valid = 1'b0;
        start        = 1'b0;
        return;
      end
    end
    acc = cyc + 1;
    @(posedge clk);
    #1;
    weight_valid = 1'b0;
    start        = 1'b0;
  endtask

  // Drive the tile and queue the expected output; stops before transfer
  // index stop_at when stop_at >= 0.
  task automatic run_tile(input bit gaps, input int stop_at, input bit start_mid);
    int    mcnt, v, acc, idx;
    item_t it;
    exp_ovf = 1'b0;
    for (int c = 0; c < 8; c++) begin
      mcnt = 0;
      for (int r = 0; r < 8; r++) begin
        idx = c * 8 + r;
        if (idx == stop_at) return;
        if (gaps && ($urandom_range(1) == 1)) begin
          weight_valid = 1'b0;
          repeat ($urandom_range(3, 1)) @(posedge clk);
          #1;
        end
        send(tile[idx], start_mid && (idx == 30), acc);
        v = int'(tile[idx]);
        if (v < 0) v = -v;
        if (v > 63) begin
          if (mcnt < 3) begin
            it.is_cc = 1'b0; it.code = 3'(r); it.cyc = acc;
            sb.push_back(it);
            mcnt++;
          end else begin
            exp_ovf = 1'b1;
          end
        end
      end
      if (mcnt == 0) begin
        for (int p = 0; p < 3; p++) begin
          it.is_cc = 1'b0; it.code = 3'b000; it.cyc = -1;
          sb.push_back(it);
        end
      end else if (mcnt < 3) begin
        it.is_cc = 1'b1; it.code = 3'b000; it.cyc = -1;
        sb.push_back(it);
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int guard;
    guard = 0;
    while (!load_mem_done && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_done_seen"}, int'(load_mem_done), 1);
    check({tag, "_sb_empty"},  sb.size(), 0);
    check({tag, "_ovf"},       int'(overflow), int'(exp_ovf));
    check({tag, "_busy"},      int'(busy), 0);
    check({tag, "_ready"},     int'(weight_ready), 0);
    repeat (3) @(negedge clk);
    check({tag, "_done_hold"}, int'(load_mem_done), 1);
    check({tag, "_ovf_hold"},  int'(overflow), int'(exp_ovf));
  endtask

  task automatic set_clean();
    for (int i = 0; i < 64; i++) tile[i] = 8'sd10;
  endtask

  // Column 0: rows 1,5 outliers; column 2: four -128 (overflow);
  // column 5: threshold boundary 63,-63 (clean) and 64,-64 (outliers).
  task automatic set_tile_a();
    set_clean();
    tile[1]  = 8'sd100;
    tile[5]  = -8'sd100;
    tile[16] = -8'sd128;
    tile[18] = -8'sd128;
    tile[20] = -8'sd128;
    tile[22] = -8'sd128;
    tile[40] = 8'sd63;
    tile[41] = -8'sd63;
    tile[42] = 8'sd64;
    tile[43] = -8'sd64;
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    weight_in    = '0;
    weight_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    // IDLE ignores weights without start.
    weight_in    = 8'sd100;
    weight_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("idle_no_start");
    weight_valid = 1'b0;

    // Clean tile: 24 pads, no change_col.
    set_clean();
    pulse_start();
    check("start1_busy", int'(busy), 1);
    run_tile(1'b0, -1, 1'b0);
    wait_done("clean");

    // Outlier tile, with a start pulse mid-scan that must be ignored.
    set_tile_a();
    pulse_start();
    check("start2_done_clr", int'(load_mem_done), 0);
    run_tile(1'b0, -1, 1'b1);
    wait_done("tile_a");

    // Same tile with random valid gaps, restarted from DONE.
    pulse_start();
    check("start3_done_clr", int'(load_mem_done), 0);
    check("start3_ovf_clr",  int'(overflow), 0);
    check("start3_busy",     int'(busy), 1);
    run_tile(1'b1, -1, 1'b0);
    wait_done("tile_a_gaps");

    // Reset in the middle of column 4 (overflow already set by column 2).
    pulse_start();
    run_tile(1'b0, 36, 1'b0);
    check("pre_reset_ovf", int'(overflow), 1);
    check("pre_reset_sb",  sb.size(), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle("mid_reset");
    rst = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check_idle("after_reset");

    // Fresh start reproduces the clean-tile sequence.
    set_clean();
    pulse_start();
    run_tile(1'b0, -1, 1'b0);
    wait_done("clean_again");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
